// File: rtl/ble_cmd_pkg.sv
// ble_cmd_pkg: shared state types and frame constants for the BLE command receiver
package ble_cmd_pkg;
    typedef enum logic {IDLE, RECV} bit_state_t;
    typedef enum logic {WAIT_HI, WAIT_LO} byte_state_t;
    localparam int DEFAULT_BAUD_DIV = 2604;
    localparam int FRAME_BITS = 10;
endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: synchronised 8N1 byte receiver with mid-bit sampling and false-start rejection
module uart_byte_rx
    import ble_cmd_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       start,
    output logic       busy,
    output logic       byte_rdy,
    output logic [7:0] data,
    output logic       frame_err
);
    localparam logic [11:0] HALF   = 12'(BAUD_DIV / 2);
    localparam logic [11:0] RELOAD = 12'(BAUD_DIV - 1);
    localparam logic [3:0]  LAST   = 4'(FRAME_BITS - 1);

    bit_state_t            state, state_nxt;
    logic                  rx_ff1, rx_ff2, rx_ff3;
    logic [11:0]           baud_cnt;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shift;
    logic                  tick;

    assign start = state == IDLE && rx_ff3 && !rx_ff2;
    assign tick  = state == RECV && baud_cnt == 12'd0;
    assign busy  = state == RECV;
    assign data  = shift[8:1];

    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = RECV;
        else if (tick && ((bit_cnt == 4'd0 && rx_ff2) || bit_cnt == LAST))
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {rx_ff1, rx_ff2, rx_ff3} <= 3'b111;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            byte_rdy  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            {rx_ff1, rx_ff2, rx_ff3} <= {rx, rx_ff1, rx_ff2};
            byte_rdy  <= tick && bit_cnt == LAST && rx_ff2;
            frame_err <= tick && bit_cnt == LAST && !rx_ff2;
            if (start) begin
                baud_cnt <= HALF;
                bit_cnt  <= '0;
            end else if (tick) begin
                baud_cnt <= RELOAD;
                shift    <= {rx_ff2, shift[FRAME_BITS-1:1]};
                bit_cnt  <= bit_cnt + 4'd1;
            end else if (state == RECV) begin
                baud_cnt <= baud_cnt - 12'd1;
            end
        end
    end
endmodule

// File: rtl/ble_cmd_rx.sv
// ble_cmd_rx: pairs received UART bytes into a 16-bit command with a sticky ready handshake
module ble_cmd_rx
    import ble_cmd_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int BYTE_TMO = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        frame_err
);
    localparam int          TW       = $clog2(BYTE_TMO);
    localparam logic [TW-1:0] TMO_LAST = TW'(BYTE_TMO - 1);

    byte_state_t   bstate, bstate_nxt;
    logic          start, busy, byte_rdy, set;
    logic [7:0]    data, hi_reg;
    logic [TW-1:0] tmo_cnt;

    uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (RX),
        .start     (start),
        .busy      (busy),
        .byte_rdy  (byte_rdy),
        .data      (data),
        .frame_err (frame_err)
    );

    assign set = bstate == WAIT_LO && byte_rdy;

    always_comb begin
        bstate_nxt = bstate;
        if (bstate == WAIT_HI)
            bstate_nxt = byte_rdy ? WAIT_LO : WAIT_HI;
        else if (byte_rdy || frame_err || tmo_cnt == TMO_LAST)
            bstate_nxt = WAIT_HI;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) bstate <= WAIT_HI;
        else        bstate <= bstate_nxt;

    // timeout only runs in the gap between bytes, never while a frame is arriving
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg  <= '0;
            tmo_cnt <= '0;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
        end else begin
            if (bstate == WAIT_HI && byte_rdy)
                hi_reg <= data;
            tmo_cnt <= (bstate == WAIT_HI || busy) ? '0 : tmo_cnt + 1'b1;
            if (set)
                cmd <= {hi_reg, data};
            cmd_rdy <= set ? 1'b1 :
                       (clr_cmd_rdy || (start && bstate == WAIT_HI)) ? 1'b0 : cmd_rdy;
        end
    end
endmodule
